// File: rtl/mem_array_ctrl_if.sv
// Request/response bus of mem_array_ctrl: read/write request in, registered read data out.
interface mem_array_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output rd_en, wr_en, addr, wdata, input  rdata, rvalid);
  modport slave  (input  rd_en, wr_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/mem_array_ctrl.sv
// Single-port memory array with registered read, init sweep after reset or clr_i,
// collision/range strobes and saturating collision count. Optional macro: PARITY_EN.
module mem_array_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 64,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int                CNT_W    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             clr_i,
  mem_array_ctrl_if.slave  bus,
  output logic             busy_o,
  output logic             coll_o,
  output logic             range_o,
  output logic [CNT_W-1:0] coll_cnt_o
`ifdef PARITY_EN
  ,
  output logic             par_err_o
`endif
);

`ifdef PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  // One extra bit so addresses up to 2^ADDR_W-1 compare correctly against DEPTH.
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic logic [MEM_W-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q, rvalid_q, coll_q, range_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt_q;
`ifdef PARITY_EN
  logic              par_q;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];
  logic              in_range, run_ok;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_wa_d;
  logic [MEM_W-1:0]  mem_wd_d, rword;

  assign in_range = {1'b0, bus.addr} < DEPTH_W;
  assign run_ok   = (state_q == ST_RUN) && !clr_i;
  assign rword    = mem[bus.addr];

  always_comb begin
    mem_we_d = 1'b0;
    mem_wa_d = bus.addr;
    mem_wd_d = enc(bus.wdata);
    if (state_q == ST_INIT) begin
      mem_we_d = 1'b1;
      mem_wa_d = ptr_q;
      mem_wd_d = enc(INIT_VAL);
    end else if (run_ok && bus.wr_en && !bus.rd_en && in_range) begin
      mem_we_d = 1'b1;
    end
  end

  // Array itself has no reset; the sweep after reset release clears it.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we_d) mem[mem_wa_d] <= mem_wd_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      busy_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      coll_q   <= 1'b0;
      range_q  <= 1'b0;
      cnt_q    <= '0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      coll_q   <= 1'b0;
      range_q  <= 1'b0;
`ifdef PARITY_EN
      par_q    <= 1'b0;
`endif
      case (state_q)
        ST_INIT: begin
          if (ptr_q == LAST) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (clr_i) begin
            state_q <= ST_INIT;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
            cnt_q   <= '0;
          end else if (bus.rd_en && bus.wr_en) begin
            coll_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          end else if (bus.rd_en) begin
            rvalid_q <= 1'b1;
            if (in_range) begin
              rdata_q <= rword[DATA_W-1:0];
`ifdef PARITY_EN
              par_q   <= ^rword;
`endif
            end else begin
              rdata_q <= '0;
              range_q <= 1'b1;
            end
          end else if (bus.wr_en && !in_range) begin
            range_q <= 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign busy_o     = busy_q;
  assign coll_o     = coll_q;
  assign range_o    = range_q;
  assign coll_cnt_o = cnt_q;
`ifdef PARITY_EN
  assign par_err_o  = par_q;
`endif

endmodule

// File: tb/tb_mem_array_ctrl.sv
// Bench for mem_array_ctrl: a 64-deep and a 48-deep instance driven with identical stimulus,
// checked every cycle against an array/countdown model, plus a directed vector table.
module tb_mem_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, rd, wr;
  logic [5:0] addr;
  logic [7:0] wdata;

  logic       busy64, coll64, range64, busy48, coll48, range48;
  logic [7:0] cnt64, cnt48;
`ifdef PARITY_EN
  logic       perr64, perr48;
`endif

  always #5 clk = ~clk;

  mem_array_ctrl_if #(.ADDR_W(6), .DATA_W(8)) if64 ();
  mem_array_ctrl_if #(.ADDR_W(6), .DATA_W(8)) if48 ();

  assign if64.rd_en = rd;   assign if48.rd_en = rd;
  assign if64.wr_en = wr;   assign if48.wr_en = wr;
  assign if64.addr  = addr; assign if48.addr  = addr;
  assign if64.wdata = wdata; assign if48.wdata = wdata;

  mem_array_ctrl #(.DEPTH(64)) u64 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .clr_i(clr), .bus(if64),
    .busy_o(busy64), .coll_o(coll64), .range_o(range64), .coll_cnt_o(cnt64)
`ifdef PARITY_EN
    , .par_err_o(perr64)
`endif
  );

  mem_array_ctrl #(.DEPTH(48)) u48 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .clr_i(clr), .bus(if48),
    .busy_o(busy48), .coll_o(coll48), .range_o(range48), .coll_cnt_o(cnt48)
`ifdef PARITY_EN
    , .par_err_o(perr48)
`endif
  );

  logic [19:0] o64, o48;
  assign o64 = {if64.rdata, if64.rvalid, busy64, coll64, range64, cnt64};
  assign o48 = {if48.rdata, if48.rvalid, busy48, coll48, range48, cnt48};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: whole array cleared when a sweep starts, sweep is just a busy countdown.
  int         dep [2] = '{64, 48};
  int         bl  [2];
  int         e_cnt [2];
  logic [7:0] mm [2][64];
  logic [7:0] e_rdata [2];
  bit         e_rvalid [2], e_coll [2], e_range [2];

  task automatic model_reset(input int d);
    bl[d] = dep[d]; e_cnt[d] = 0; e_rdata[d] = 8'h00;
    e_rvalid[d] = 0; e_coll[d] = 0; e_range[d] = 0;
    for (int i = 0; i < 64; i++) mm[d][i] = 8'h00;
  endtask

  task automatic model_step(input int d);
    e_rvalid[d] = 0; e_coll[d] = 0; e_range[d] = 0;
    if (bl[d] > 0) bl[d]--;
    else if (clr) begin
      bl[d] = dep[d]; e_cnt[d] = 0;
      for (int i = 0; i < 64; i++) mm[d][i] = 8'h00;
    end else if (rd && wr) begin
      e_coll[d] = 1;
      if (e_cnt[d] < 255) e_cnt[d]++;
    end else if (rd) begin
      e_rvalid[d] = 1;
      if (int'(addr) < dep[d]) e_rdata[d] = mm[d][addr];
      else begin e_rdata[d] = 8'h00; e_range[d] = 1; end
    end else if (wr) begin
      if (int'(addr) < dep[d]) mm[d][addr] = wdata;
      else e_range[d] = 1;
    end
  endtask

  function automatic logic [19:0] m_out(input int d);
    return {e_rdata[d], e_rvalid[d], bl[d] > 0, e_coll[d], e_range[d], 8'(e_cnt[d])};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin model_step(0); model_step(1); end
    #1;
    chk("dut64 outputs", {12'h0, o64}, {12'h0, m_out(0)});
    chk("dut48 outputs", {12'h0, o48}, {12'h0, m_out(1)});
  endtask

  task automatic idle();
    clr = 0; rd = 0; wr = 0;
  endtask

  // Ticks until the 64-deep instance leaves its sweep, with reads issued throughout.
  task automatic sweep_len(output int n64, output int n48, output int rv);
    n64 = 0; n48 = 0; rv = 0;
    for (int k = 1; k <= 200; k++) begin
      rd = 1; wr = 0; addr = 6'($urandom_range(0, 63));
      tick();
      if (busy64 && if64.rvalid) rv++;
      if (n48 == 0 && !busy48) n48 = k;
      if (!busy64) begin n64 = k; break; end
    end
    idle();
  endtask

  typedef struct {
    bit         rd, wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] e_rdata;
    bit         e_rvalid, e_coll;
  } vec_t;

  vec_t tbl [13];
  int   s64, s48, rv;

  initial begin
    tbl[0]  = '{1, 0, 6'd0,  8'h00, 8'h00, 1, 0};
    tbl[1]  = '{1, 0, 6'd63, 8'h00, 8'h00, 1, 0};
    tbl[2]  = '{0, 1, 6'd5,  8'hA5, 8'h00, 0, 0};
    tbl[3]  = '{1, 0, 6'd5,  8'h00, 8'hA5, 1, 0};
    tbl[4]  = '{1, 0, 6'd6,  8'h00, 8'h00, 1, 0};
    tbl[5]  = '{0, 1, 6'd10, 8'h3C, 8'h00, 0, 0};
    tbl[6]  = '{1, 0, 6'd10, 8'h00, 8'h3C, 1, 0};
    tbl[7]  = '{0, 0, 6'd10, 8'h00, 8'h3C, 0, 0};
    tbl[8]  = '{1, 1, 6'd10, 8'h77, 8'h3C, 0, 1};
    tbl[9]  = '{1, 0, 6'd10, 8'h00, 8'h3C, 1, 0};
    tbl[10] = '{0, 1, 6'd63, 8'h5A, 8'h3C, 0, 0};
    tbl[11] = '{1, 0, 6'd63, 8'h00, 8'h5A, 1, 0};
    tbl[12] = '{1, 0, 6'd5,  8'h00, 8'hA5, 1, 0};

    rst_n = 0; idle(); addr = 0; wdata = 0;
    model_reset(0); model_reset(1);
    repeat (3) tick();
    chk("reset state", {12'h0, o64}, {12'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

    rst_n = 1;
    sweep_len(s64, s48, rv);
    chk("sweep length 64", s64, 64);
    chk("sweep length 48", s48, 48);
    chk("strobes during sweep", rv, 0);

    for (int i = 0; i < 13; i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; wdata = tbl[i].wdata;
      tick();
      chk($sformatf("vector %0d", i), {if64.rdata, if64.rvalid, coll64},
          {tbl[i].e_rdata, tbl[i].e_rvalid, tbl[i].e_coll});
    end
    idle();

    // Long collision burst: counter saturates, memory untouched.
    rd = 1; wr = 1; addr = 6'd5; wdata = 8'h00;
    repeat (300) tick();
    chk("coll count saturated", cnt64, 8'd255);
    chk("coll strobe held", coll64, 1'b1);
    rd = 1; wr = 0; addr = 6'd5;
    tick();
    chk("addr5 after collisions", if64.rdata, 8'hA5);

    // Out-of-range accesses on the 48-deep instance.
    addr = 6'd50; rd = 1; wr = 0;
    tick();
    chk("oor read 48", {if48.rdata, if48.rvalid, range48}, {8'h00, 1'b1, 1'b1});
    chk("in-range read 64", range64, 1'b0);
    rd = 0; wr = 1; wdata = 8'hFF;
    tick();
    chk("oor write 48", range48, 1'b1);
    chk("oor write strobe", if48.rvalid, 1'b0);
    for (int a = 0; a < 48; a++) begin
      rd = 1; wr = 0; addr = 6'(a);
      tick();
    end
    idle();

    // Clear request: sweep again, counter cleared, written data gone.
    wr = 1; addr = 6'd10; wdata = 8'h3C;
    tick();
    idle(); clr = 1;
    tick();
    clr = 0;
    chk("busy after clr", busy64, 1'b1);
    sweep_len(s64, s48, rv);
    chk("clr sweep length 64", s64, 64);
    chk("clr sweep length 48", s48, 48);
    chk("reads ignored in sweep", rv, 0);
    rd = 1; addr = 6'd10;
    tick();
    chk("addr10 after clr", if64.rdata, 8'h00);
    chk("coll count after clr", cnt64, 8'd0);
    idle();

    // Reset in the middle of a sweep restarts it from zero.
    clr = 1;
    tick();
    clr = 0;
    repeat (20) tick();
    rst_n = 0;
    #1;
    model_reset(0); model_reset(1);
    chk("busy in reset", busy64, 1'b1);
    chk("rdata in reset", if64.rdata, 8'h00);
    repeat (2) tick();
    rst_n = 1;
    sweep_len(s64, s48, rv);
    chk("sweep after mid reset", s64, 64);

    // Random traffic with occasional clears.
    for (int k = 0; k < 1500; k++) begin
      rd    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      addr  = 6'($urandom_range(0, 63));
      wdata = 8'($urandom);
      clr   = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_array_ctrl.md
Name: mem_array_ctrl

Overview:
- Parametrised single-port synchronous memory array with registered read, read-valid strobe and hardware initialisation sweep.
- Successor to the fixed 8-entry byte store. Default geometry is 64x8, driven from the user-area GPIO/Wishbone glue.
- Adds the following:
  - depth/width generics
  - an init state machine that clears the array after reset or on request
  - collision and range reporting
  - a saturating collision counter

Parameters:
- DATA_W, 8, word width in bits.
- DEPTH, 64, number of words; any value 2..1024, power of two not required.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- INIT_VAL, 0, value written to every word during an init sweep.
- CNT_W, 8, width of the collision counter.

Ports:
- wb_clk_i  in  1  clock; all state on rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  request re-initialisation (single-cycle pulse, sampled only when not busy).
- rd_en  in  1  read request.
- wr_en  in  1  write request.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  one-cycle strobe: rdata updated this cycle.
- busy_o  out  1  init sweep in progress; requests ignored.
- coll_o  out  1  one-cycle strobe: rd_en and wr_en were both high.
- range_o  out  1  one-cycle strobe: accepted request had addr >= DEPTH.
- coll_cnt_o  out  CNT_W  saturating count of collisions since last reset or clear.

Behaviour:
- Reset (wb_rst_ni low, asynchronous) forces these values:
  - rdata=0, rvalid=0, coll_o=0, range_o=0, coll_cnt_o=0
  - busy_o=1, FSM=INIT, sweep pointer=0
  - Array contents are not reset directly.
- FSM states: INIT, RUN.
  - INIT: each cycle writes INIT_VAL to mem[ptr] and increments ptr. When ptr==DEPTH-1 is written, the next state is RUN and busy_o falls. The sweep takes exactly DEPTH cycles after reset release.
  - RUN: serves requests. clr_i=1 sets ptr=0 and enters INIT next cycle; any request in that same cycle is ignored. clr_i also clears coll_cnt_o.
- In INIT:
  - rd_en/wr_en are ignored, with no strobes.
  - clr_i is ignored.
- In RUN, evaluated per cycle:
  - Write (wr_en=1, rd_en=0, addr<DEPTH): mem[addr]<=wdata. The written value is readable from the next cycle.
  - Read (rd_en=1, wr_en=0, addr<DEPTH): next cycle rdata=mem[addr] and rvalid=1 (latency 1).
  - Both high: no memory access, rdata holds, coll_o=1 next cycle, coll_cnt_o increments and saturates at 2^CNT_W-1.
  - Neither high: rdata holds, rvalid=0.
  - addr>=DEPTH on a read or write: no memory access. range_o=1 next cycle. A read additionally gives rdata=0 with rvalid=1.
  - Back-to-back reads: one per cycle, rvalid continuously high.
  - Read of an address written in the previous cycle returns the new data.
- rdata holds its last value between reads, including through INIT; it is cleared only by reset.
- Reset asserted mid-sweep or mid-read: immediate return to reset values; the sweep restarts from 0 after release.

Optional Feature:
- PARITY_EN: when defined, each word stores one extra even-parity bit computed from wdata, or from INIT_VAL during a sweep.
  - Reads check parity. On mismatch, an added output par_err_o (1 bit) pulses together with rvalid.
  - par_err_o resets to 0.
- When undefined:
  - no parity storage and no par_err_o port
  - array is DEPTH x DATA_W

Test Plan:
- Release reset with defaults, keep clr_i=0 -> busy_o high for exactly 64 cycles. Then read addr 0 and addr 63 -> rdata=0x00, rvalid pulses one cycle after each read.
- Write 0xA5 to addr 5, next cycle read addr 5 -> rdata=0xA5 with rvalid=1. Then read addr 6 -> 0x00.
- Hold rd_en=wr_en=1 for 300 cycles with CNT_W=8 -> coll_o high each following cycle, coll_cnt_o saturates at 255, no memory change.
- DEPTH=48: read addr 50 -> rdata=0, rvalid=1, range_o=1. Write 0xFF to addr 50 -> range_o=1 and a full sweep of 0..47 shows no change.
- Write 0x3C to addr 10, pulse clr_i -> busy_o high for 64 cycles, reads ignored meanwhile. Then read addr 10 -> 0x00 and coll_cnt_o=0.
- Drop wb_rst_ni during a sweep at cycle 20 -> busy_o stays 1. After release, exactly 64 more busy cycles.
